// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, round constants, state types
// and the GF(2^8) helpers used by the round datapath.
package aes_pkg;

  localparam int NR = 10;

  localparam logic [7:0] RCON [1:NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef logic [7:0] byte_t;
  typedef byte_t [0:3] word_t;   // one column, row 0 in the top byte
  typedef word_t [0:3] state_t;  // [col][row]; byte i lives at s[i/4][i%4]

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_e;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  // Row r of the result uses coefficients 2,3,1,1 starting at a[r].
  function automatic word_t mix_col(input word_t a);
    word_t m;
    logic [1:0] i0, i1, i2, i3;
    m = '0;
    for (int r = 0; r < 4; r++) begin
      i0 = 2'(r);
      i1 = 2'(r + 1);
      i2 = 2'(r + 2);
      i3 = 2'(r + 3);
      m[i0] = xtime(a[i0]) ^ xtime(a[i1]) ^ a[i1] ^ a[i2] ^ a[i3];
    end
    return m;
  endfunction

  // Row r rotates left by r columns.
  function automatic state_t shift_rows(input state_t s);
    state_t o;
    logic [1:0] c2, r2, src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        c2  = 2'(c);
        r2  = 2'(r);
        src = c2 + r2;
        o[c2][r2] = s[src][r2];
      end
    end
    return o;
  endfunction

  function automatic byte_t rcon_of(input logic [3:0] n);
    return (n >= 4'd1 && n <= 4'd10) ? RCON[n] : 8'h00;
  endfunction

endpackage

// File: rtl/aes_if.sv
// Crypto accelerator bus shared by the AES cores: key/text load strobes
// towards the core, busy/done/result back to the requester.
interface aes_if;
  logic         kld;
  logic [127:0] key;
  logic         ld;
  logic [127:0] text_in;
  logic         busy;
  logic         done;
  logic [127:0] text_out;

  modport master (
    output kld, key, ld, text_in,
    input  busy, done, text_out
  );

  modport slave (
    input  kld, key, ld, text_in,
    output busy, done, text_out
  );
endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the
// FIPS-197 affine transform. Purely combinational.
module aes_sbox
  import aes_pkg::*;
(
  input  byte_t a,
  output byte_t y
);

  function automatic byte_t gmul(input byte_t x, input byte_t z);
    byte_t p, t, m;
    p = '0;
    t = x;
    m = z;
    for (int i = 0; i < 8; i++) begin
      if (m[0]) p = p ^ t;
      t = xtime(t);
      m = m >> 1;
    end
    return p;
  endfunction

  byte_t sq, inv;

  // inv = a^254, which is a^-1 for nonzero a and 0 for a = 0
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_cipher.sv
// Iterative AES-128 encryption core: one round per clk, forward key
// schedule expanded on the fly, 11-cycle block latency.
//
//   state | meaning
//   IDLE  | waiting for ld, busy=0
//   RUN   | one round per clk, rcnt counts 1..10; round 10 raises done
module aes_cipher
  import aes_pkg::*;
(
  input logic  clk,
  input logic  rst,
  aes_if.slave bus
);

  fsm_e         state, state_n;
  logic         busy, load, step, last;
  logic         done_r;
  logic [3:0]   rcnt;
  logic [127:0] key_r, k_sel, text_out_r;
  state_t       st, rk, rk_n, sb, sr, mc;
  word_t        sw, kt;
  byte_t        rc;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.ld) state_n = RUN;
      RUN:     if (rcnt == 4'(NR)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    load = 1'b0;
    step = 1'b0;
    last = 1'b0;
    case (state)
      IDLE: load = bus.ld;
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        last = (rcnt == 4'(NR));
      end
      default: ;
    endcase
  end

  // A same-edge kld feeds the new key straight into the block being started.
  assign k_sel = bus.kld ? bus.key : key_r;

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      aes_sbox u_sbox (.a(st[c][r]), .y(sb[c][r]));
    end
    aes_sbox u_ksbox (.a(rk[3][(c + 1) % 4]), .y(sw[c]));
    assign mc[c] = mix_col(sr[c]);
  end

  assign rc = rcon_of(rcnt);
  assign sr = shift_rows(sb);

  // Key expansion written as flat XOR sums so no word depends on another net of rk_n.
  assign kt   = sw ^ {rc, 24'h000000};
  assign rk_n = {rk[0] ^ kt,
                 rk[1] ^ rk[0] ^ kt,
                 rk[2] ^ rk[1] ^ rk[0] ^ kt,
                 rk[3] ^ rk[2] ^ rk[1] ^ rk[0] ^ kt};

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_r      <= '0;
      st         <= '0;
      rk         <= '0;
      rcnt       <= '0;
      text_out_r <= '0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.kld) key_r <= bus.key;
      if (load) begin
        st   <= bus.text_in ^ k_sel;
        rk   <= k_sel;
        rcnt <= 4'd1;
      end else if (last) begin
        text_out_r <= sr ^ rk_n;
        done_r     <= 1'b1;
        rcnt       <= '0;
      end else if (step) begin
        st   <= mc ^ rk_n;
        rk   <= rk_n;
        rcnt <= rcnt + 4'd1;
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done_r;
  assign bus.text_out = text_out_r;

endmodule

// File: tb/tb_aes_cipher.sv
// Scoreboard bench for aes_cipher: FIPS-197 known answers plus randomized
// blocks checked against a byte-array reference model of AES-128.
module tb_aes_cipher;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0;
  logic rst = 1'b0;

  aes_if bus ();

  aes_cipher dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic [7:0]   sbox_t [256];
  logic [127:0] exp_q [$];
  int           edge_q [$];
  logic [127:0] key_model = '0;
  logic [127:0] last_ct = '0;
  int           next_free = 0;
  int           busy_start = 0;
  int           busy_end = 0;
  logic         exp_done;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   a [4];
    logic [127:0] out;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
              ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++)
      s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int i = 0; i < 16; i++) t[i] = s[(i%4) + 4*(((i/4) + (i%4)) % 4)];
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) a[r] = t[4*c + r];
        for (int r = 0; r < 4; r++)
          s[4*c + r] = (rnd < 10) ? (gmul(a[r], 8'h02) ^ gmul(a[(r+1)%4], 8'h03)
                                     ^ a[(r+2)%4] ^ a[(r+3)%4])
                                  : a[r];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31 - 8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = s[i];
    return out;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s after edge %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  // ---------------- stimulus ----------------
  // One cycle of inputs; the block is logged in the scoreboard if the core must accept it.
  task automatic drive(input logic ld_v, input logic [127:0] pt, input logic kld_v,
                       input logic [127:0] k, input logic kat_v, input logic [127:0] kat);
    logic [127:0] kk;
    int e;
    @(negedge clk);
    bus.ld      = ld_v;
    bus.text_in = pt;
    bus.kld     = kld_v;
    bus.key     = k;
    e  = cyc + 1;
    kk = kld_v ? k : key_model;
    if (ld_v && rst && e >= next_free) begin
      exp_q.push_back(kat_v ? kat : aes_enc(kk, pt));
      edge_q.push_back(e + 10);
      busy_start = e;
      busy_end   = e + 10;
      next_free  = e + 11;
    end
    if (kld_v && rst) key_model = k;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b0;
    bus.ld  = 1'b0;
    bus.kld = 1'b0;
    exp_q.delete();
    edge_q.delete();
    busy_start = 0;
    busy_end   = 0;
    next_free  = 0;
    key_model  = '0;
    last_ct    = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      exp_done = (edge_q.size() > 0) && (edge_q[0] == cyc);
      check("done", 128'(bus.done), 128'(exp_done));
      if (exp_done) begin
        check("text_out at done", bus.text_out, exp_q[0]);
        last_ct = exp_q.pop_front();
        void'(edge_q.pop_front());
      end
      check("text_out hold", bus.text_out, last_ct);
      check("busy", 128'(bus.busy), 128'(cyc >= busy_start && cyc < busy_end));
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] inv, b, cst;
    logic [127:0] k, pt;
    int gap;

    bus.ld = 1'b0;
    bus.kld = 1'b0;
    bus.key = '0;
    bus.text_in = '0;

    cst = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sbox_t[x] = b;
    end
    check("model App.B", aes_enc(KEY_B, PT_B), CT_B);
    check("model C.1", aes_enc(KEY_C, PT_C), CT_C);

    repeat (3) @(negedge clk);
    rst = 1'b1;

    // App. B with a separate key load
    drive(1'b0, '0, 1'b1, KEY_B, 1'b0, '0);
    drive(1'b1, PT_B, 1'b0, '0, 1'b1, CT_B);
    idle(12);
    // C.1 with key and ld on the same edge
    drive(1'b1, PT_C, 1'b1, KEY_C, 1'b1, CT_C);
    idle(12);
    // all-zero key: loaded first, then on the same edge as ld
    drive(1'b0, '0, 1'b1, '0, 1'b0, '0);
    drive(1'b1, '0, 1'b0, '0, 1'b1, CT_Z);
    idle(12);
    drive(1'b0, '0, 1'b1, KEY_C, 1'b0, '0);
    drive(1'b1, '0, 1'b1, '0, 1'b1, CT_Z);
    idle(12);

    // kld mid-block leaves the running block alone, next block takes the new key
    drive(1'b0, '0, 1'b1, KEY_B, 1'b0, '0);
    drive(1'b1, PT_B, 1'b0, '0, 1'b1, CT_B);
    idle(4);
    drive(1'b0, '0, 1'b1, KEY_C, 1'b0, '0);
    idle(6);
    drive(1'b1, PT_C, 1'b0, '0, 1'b1, CT_C);
    idle(12);

    // ld while busy, including the edge that raises done, is ignored
    drive(1'b1, rand128(), 1'b0, '0, 1'b0, '0);
    idle(2);
    drive(1'b1, rand128(), 1'b0, '0, 1'b0, '0);
    idle(6);
    drive(1'b1, rand128(), 1'b0, '0, 1'b0, '0);
    idle(12);

    // ld held high: a block every 11 cycles
    for (int i = 0; i < 40; i++) drive(1'b1, rand128(), 1'b0, '0, 1'b0, '0);
    idle(12);

    // randomized keys, plaintexts, gaps and stray ld pulses
    for (int n = 0; n < 12; n++) begin
      k  = rand128();
      pt = rand128();
      if ($urandom_range(0, 1) == 1) begin
        drive(1'b0, '0, 1'b1, k, 1'b0, '0);
        drive(1'b1, pt, 1'b0, '0, 1'b0, '0);
      end else begin
        drive(1'b1, pt, 1'b1, k, 1'b0, '0);
      end
      gap = $urandom_range(4, 16);
      for (int g = 0; g < gap; g++)
        drive($urandom_range(0, 3) == 0, rand128(), $urandom_range(0, 7) == 0, rand128(), 1'b0, '0);
    end
    idle(12);

    // reset in round 6 aborts the block and clears key_r and text_out
    drive(1'b1, PT_B, 1'b1, KEY_B, 1'b1, CT_B);
    idle(5);
    do_reset();
    idle(12);
    drive(1'b1, '0, 1'b0, '0, 1'b1, CT_Z);
    idle(12);
    drive(1'b1, PT_B, 1'b1, KEY_B, 1'b1, CT_B);
    idle(12);

    for (int i = 0; i < 40 && edge_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
